corr_flag_ctrl: RTL and testbench



---
 rtl/corr_flag_ctrl_pkg.sv | 19 +
 rtl/corr_flag_ctrl_peak.sv | 38 +++
 rtl/corr_flag_ctrl.sv | 108 ++++++++++
 tb/tb_corr_flag_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_flag_ctrl_pkg.sv
// Shared types and constants for the correlation flag controller and its
// external 4-bit sequencing counter.
package corr_flag_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Counter values at which the external counter decodes each strobe.
  localparam logic [3:0] CNT_S3  = 4'd1;
  localparam logic [3:0] CNT_S1  = 4'd2;
  localparam logic [3:0] CNT_S2  = 4'd4;
  localparam logic [3:0] CNT_SAT = 4'd5;

endpackage

// File: rtl/corr_flag_ctrl_peak.sv
// Window-gated running maximum of the correlation samples. The window opens
// on open and closes after the close cycle, so a coincident sample counts.
module corr_peak_hold #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         en,
  input  logic         open,
  input  logic         close,
  input  logic [W-1:0] sample,
  input  logic         valid,
  output logic [W-1:0] peak
);

  logic [W-1:0] peak_reg;
  logic         win_reg;
  logic         active;

  assign active = en & (open | win_reg);
  // peak already includes the current sample so the caller can load it on close.
  assign peak = (active && valid && (sample > peak_reg)) ? sample : peak_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      peak_reg <= '0;
      win_reg  <= 1'b0;
    end else if (clr) begin
      peak_reg <= '0;
      win_reg  <= 1'b0;
    end else begin
      peak_reg <= peak;
      win_reg  <= active & ~close;
    end
  end

endmodule

// File: rtl/corr_flag_ctrl.sv
// Threshold-triggered detection controller: sequences the external counter,
// raises the flag, captures the peak and reports it over valid/ready.
module corr_flag_ctrl
  import corr_flag_ctrl_pkg::*;
#(
  parameter int W       = 16,
  parameter int CW      = 8,
  parameter int MW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          EN,
  input  logic [W-1:0]  CorrIn,
  input  logic          CorrValid,
  input  logic [W-1:0]  Threshold,
  input  logic          S1,
  input  logic          S2,
  input  logic          S3,
  output logic          CntEN,
  output logic          CntReset,
  output logic          Flag,
  output logic [W-1:0]  OutCorr,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [CW-1:0] DetCount,
  output logic [MW-1:0] Missed,
  output logic          ErrTimeout
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t       state;
  logic [7:0]   wdog;
  logic         trigger;
  logic         in_run;
  logic [W-1:0] peak;

  assign trigger  = EN & CorrValid & (CorrIn >= Threshold);
  assign in_run   = (state == ST_RUN);
  assign CntEN    = in_run;
  assign CntReset = ~in_run;

  corr_peak_hold #(.W(W)) u_peak (
    .Clk    (Clk),
    .Reset  (Reset),
    .clr    ((state == ST_IDLE) & trigger),
    .en     (in_run),
    .open   (S3),
    .close  (S2),
    .sample (CorrIn),
    .valid  (CorrValid),
    .peak   (peak)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      wdog       <= '0;
      Flag       <= 1'b0;
      OutCorr    <= '0;
      OutValid   <= 1'b0;
      DetCount   <= '0;
      Missed     <= '0;
      ErrTimeout <= 1'b0;
    end else begin
      ErrTimeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          Flag <= 1'b0;
          if (trigger) begin
            state <= ST_RUN;
            wdog  <= '0;
          end
        end
        ST_RUN: begin
          if (!EN) begin
            state <= ST_IDLE;
            Flag  <= 1'b0;
          end else if (S2) begin
            // S2 beats a coincident S1, so the flag always ends low.
            Flag     <= 1'b0;
            OutCorr  <= peak;
            OutValid <= 1'b1;
            state    <= ST_REPORT;
          end else if (wdog == WD_LAST) begin
            state      <= ST_IDLE;
            Flag       <= 1'b0;
            ErrTimeout <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
            if (S1) Flag <= 1'b1;
          end
        end
        ST_REPORT: begin
          if (trigger && (Missed != {MW{1'b1}})) Missed <= Missed + 1'b1;
          if (OutReady) begin
            OutValid <= 1'b0;
            DetCount <= DetCount + 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corr_flag_ctrl.sv
// Directed bench for corr_flag_ctrl with an attached counter model and a
// transaction-level reference model checked every cycle.
module tb_corr_flag_ctrl;

  localparam int W = 16, CW = 8, MW = 8, TIMEOUT = 15;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          EN = 1'b0;
  logic [W-1:0]  CorrIn = '0;
  logic          CorrValid = 1'b0;
  logic [W-1:0]  Threshold = 16'h0100;
  logic          S1, S2, S3;
  logic          CntEN, CntReset, Flag, OutValid, ErrTimeout;
  logic          OutReady = 1'b0;
  logic [W-1:0]  OutCorr;
  logic [CW-1:0] DetCount;
  logic [MW-1:0] Missed;

  int n_assert = 0;
  int n_fail   = 0;
  int flag_hi  = 0;

  corr_flag_ctrl #(.W(W), .CW(CW), .MW(MW), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .EN(EN), .CorrIn(CorrIn), .CorrValid(CorrValid),
    .Threshold(Threshold), .S1(S1), .S2(S2), .S3(S3), .CntEN(CntEN),
    .CntReset(CntReset), .Flag(Flag), .OutCorr(OutCorr), .OutValid(OutValid),
    .OutReady(OutReady), .DetCount(DetCount), .Missed(Missed), .ErrTimeout(ErrTimeout)
  );

  always #5 Clk = ~Clk;

  // External 4-bit sequencing counter; sup_s2 hides S2 for the watchdog test.
  logic [3:0] cnt;
  logic       sup_s2 = 1'b0;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                       cnt <= 4'd0;
    else if (CntReset)               cnt <= 4'd0;
    else if (CntEN && cnt != 4'd5)   cnt <= cnt + 4'd1;
  end
  assign S3 = (cnt == 4'd1);
  assign S1 = (cnt == 4'd2);
  assign S2 = (cnt == 4'd4) & ~sup_s2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 detecting, 2 report pending.
  int  m_mode, m_age, m_det, m_missed, m_corr;
  bit  m_flag, m_valid, m_err, m_win;
  int  win_q[$];

  task automatic m_reset();
    m_mode = 0; m_age = 0; m_det = 0; m_missed = 0; m_corr = 0;
    m_flag = 0; m_valid = 0; m_err = 0; m_win = 0;
    win_q.delete();
  endtask

  task automatic m_step();
    bit trig;
    int mx;
    trig  = EN && CorrValid && (CorrIn >= Threshold);
    m_err = 0;
    case (m_mode)
      0: begin
        m_flag = 0;
        if (trig) begin m_mode = 1; m_age = 0; m_win = 0; win_q.delete(); end
      end
      1: begin
        m_age++;
        if (!EN) begin
          m_mode = 0; m_flag = 0;
        end else begin
          if (S3) m_win = 1;
          if (m_win && CorrValid) win_q.push_back(int'(CorrIn));
          if (S2) begin
            mx = 0;
            foreach (win_q[i]) if (win_q[i] > mx) mx = win_q[i];
            m_flag = 0; m_corr = mx; m_valid = 1; m_mode = 2; m_win = 0;
          end else if (m_age == TIMEOUT) begin
            m_mode = 0; m_flag = 0; m_err = 1;
          end else if (S1) begin
            m_flag = 1;
          end
        end
      end
      default: begin
        if (trig && m_missed < 255) m_missed++;
        if (OutReady) begin m_valid = 0; m_det = (m_det + 1) % 256; m_mode = 0; end
      end
    endcase
  endtask

  always @(posedge Clk or posedge Reset) begin
    if (Reset) m_reset();
    else       m_step();
  end

  always @(negedge Clk) begin
    if (!Reset) begin
      if (Flag) flag_hi++;
      chk("flag",     32'(Flag),       32'(m_flag));
      chk("outvalid", 32'(OutValid),   32'(m_valid));
      if (m_valid) chk("outcorr", 32'(OutCorr), 32'(m_corr));
      chk("detcount", 32'(DetCount),   32'(m_det));
      chk("missed",   32'(Missed),     32'(m_missed));
      chk("errto",    32'(ErrTimeout), 32'(m_err));
      chk("cnten",    32'(CntEN),      32'(m_mode == 1));
      chk("cntreset", 32'(CntReset),   32'(m_mode != 1));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    CorrValid = v;
    CorrIn    = d;
  endtask

  int pulse_at, pulses;

  initial begin
    Reset = 1'b1;
    tick(); tick();
    chk("rst_cntreset", 32'(CntReset), 32'd1);
    chk("rst_cnten",    32'(CntEN),    32'd0);
    chk("rst_outvalid", 32'(OutValid), 32'd0);
    chk("rst_det",      32'(DetCount), 32'd0);
    Reset = 1'b0;
    EN = 1'b1;
    tick();
    $display("reset: outputs cleared");

    // Nominal detection; the sample before S3 lies outside the window.
    flag_hi = 0;
    drive(1, 16'h0120); tick();
    drive(1, 16'h0400); tick();
    drive(1, 16'h0150); tick();
    drive(1, 16'h0300); tick();
    chk("nom_flag_rise", 32'(Flag), 32'd1);
    drive(1, 16'h0200); tick();
    drive(0, 16'h0000); tick();
    chk("nom_outvalid", 32'(OutValid), 32'd1);
    chk("nom_outcorr",  32'(OutCorr),  32'h0300);
    chk("nom_flag_len", 32'(flag_hi),  32'd2);
    OutReady = 1'b1; tick(); OutReady = 1'b0;
    chk("nom_det", 32'(DetCount), 32'd1);
    $display("nominal: OutCorr=0x%0h DetCount=%0d", OutCorr, DetCount);

    // Just below threshold: nothing starts.
    drive(1, 16'h00FF); tick(); tick(); tick();
    chk("below_cntreset", 32'(CntReset), 32'd1);
    chk("below_cnten",    32'(CntEN),    32'd0);
    drive(0, 16'h0000); tick();
    $display("below threshold: idle held");

    // Trigger at exactly threshold; peak arrives coincident with S2; then backpressure.
    drive(1, 16'h0100); tick();
    drive(0, 16'h0000); tick();
    drive(1, 16'h0110); tick();
    drive(0, 16'h0000); tick();
    tick();
    drive(1, 16'h0999); tick();
    drive(0, 16'h0000); tick();
    chk("bp_outcorr", 32'(OutCorr), 32'h0999);
    for (int k = 0; k < 20; k++) begin
      if (k == 3 || k == 8 || k == 13) drive(1, 16'h0500);
      else                             drive(0, 16'h0000);
      tick();
      chk("bp_hold_valid", 32'(OutValid), 32'd1);
      chk("bp_hold_corr",  32'(OutCorr),  32'h0999);
    end
    drive(0, 16'h0000);
    chk("bp_missed", 32'(Missed), 32'd3);
    OutReady = 1'b1; tick(); OutReady = 1'b0;
    tick();
    chk("bp_det", 32'(DetCount), 32'd2);
    $display("backpressure: Missed=%0d DetCount=%0d", Missed, DetCount);

    // Watchdog: S2 suppressed, abort 15 edges after entering RUN.
    sup_s2 = 1'b1;
    pulse_at = -1; pulses = 0;
    drive(1, 16'h0200); tick();
    drive(0, 16'h0000);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ErrTimeout) begin pulses++; pulse_at = k; end
    end
    sup_s2 = 1'b0;
    chk("wd_pulse_at", 32'(pulse_at), 32'd15);
    chk("wd_pulses",   32'(pulses),   32'd1);
    chk("wd_idle",     32'(CntReset), 32'd1);
    chk("wd_det",      32'(DetCount), 32'd2);
    $display("watchdog: pulse after %0d cycles", pulse_at);

    // EN drops the cycle after S1.
    drive(1, 16'h0200); tick();
    drive(0, 16'h0000); tick(); tick(); tick();
    chk("en_flag_set", 32'(Flag), 32'd1);
    EN = 1'b0; tick();
    chk("en_flag_clr", 32'(Flag),     32'd0);
    chk("en_noreport", 32'(OutValid), 32'd0);
    tick(); tick(); tick(); tick(); tick();
    chk("en_noreport2", 32'(OutValid), 32'd0);
    EN = 1'b1; tick();
    $display("enable abort: no report");

    // Asynchronous reset mid-RUN.
    drive(1, 16'h0200); tick();
    drive(0, 16'h0000); tick(); tick(); tick();
    #2 Reset = 1'b1; #1;
    chk("arst_flag",     32'(Flag),     32'd0);
    chk("arst_det",      32'(DetCount), 32'd0);
    chk("arst_missed",   32'(Missed),   32'd0);
    chk("arst_cntreset", 32'(CntReset), 32'd1);
    tick(); Reset = 1'b0; tick();
    $display("reset mid-run: outputs cleared");

    // 256 completed detections wrap DetCount.
    OutReady = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(1, 16'h0200); tick();
      drive(0, 16'h0000);
      repeat (6) tick();
      if (i == 254) chk("wrap_255", 32'(DetCount), 32'd255);
    end
    chk("wrap_0", 32'(DetCount), 32'd0);
    $display("wrap: DetCount=%0d", DetCount);

    // 300 triggers while a report is pending saturate Missed.
    OutReady = 1'b0;
    drive(1, 16'h0200); tick();
    drive(0, 16'h0000);
    repeat (5) tick();
    drive(1, 16'h0500);
    repeat (300) tick();
    drive(0, 16'h0000);
    chk("sat_missed",   32'(Missed),   32'd255);
    chk("sat_outvalid", 32'(OutValid), 32'd1);
    $display("saturation: Missed=%0d", Missed);

    // Reset during REPORT drops OutValid at once.
    #2 Reset = 1'b1; #1;
    chk("arst_outvalid", 32'(OutValid), 32'd0);
    chk("arst_missed2",  32'(Missed),   32'd0);
    tick(); Reset = 1'b0; tick();
    $display("reset mid-report: OutValid=%0d", OutValid);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
